classifier_head_batch: RTL and testbench
========================================

CLASSIFIER_HEAD_BATCH -- requirements
Module: classifier_head_batch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bias element width.
REQ-002 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH, score element width.
REQ-003 SHALL have parameter NUM_CLASSES, default 10, classes per image (2..64).
REQ-004 SHALL have parameter BATCH, default 10, images per batch (1..256).
REQ-005 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, level sampled; begins a batch when idle.
REQ-008 SHALL have port abort, input, 1, synchronous batch cancel.
REQ-009 SHALL have port fetch_req, output, 1, one-cycle request to the fetcher for image image_idx.
REQ-010 SHALL have port image_idx, output, clog2(BATCH) (min 1), current image number.
REQ-011 SHALL have port scores_valid, input, 1, one-cycle pulse from the fetcher.
REQ-012 SHALL have port scores, input, NUM_CLASSES x ACC_WIDTH signed.
REQ-013 SHALL have port bias, input, NUM_CLASSES x DATA_WIDTH signed, held static.
REQ-014 SHALL have ports busy (1), result_valid (1), result_class (clog2(NUM_CLASSES)), result_onehot (NUM_CLASSES), result_score (ACC_WIDTH+1 signed), done (1), all outputs.

Function
REQ-015 SHALL implement states IDLE, REQ, WAIT, SCAN, EMIT.
REQ-016 IDLE: start=1 -> REQ, image_idx=0; busy SHALL be 1 in every state except IDLE.
REQ-017 REQ: fetch_req=1 for exactly one cycle -> WAIT.
REQ-018 WAIT: scores_valid=1 -> SCAN, registering sum[k] = sext(scores[k]) + sext(bias[k]) at ACC_WIDTH+1 bits (no overflow, no saturation); scores_valid in any other state SHALL be ignored.
REQ-019 SCAN: one class per cycle, k=0..NUM_CLASSES-1; class 0 loads the running max, later classes replace it only if strictly greater (signed), so ties resolve to the lowest index.
REQ-020 After the last class, SHALL enter EMIT; result_valid=1 for exactly one cycle, cycle t+NUM_CLASSES+1 where t is the cycle scores_valid was accepted.
REQ-021 result_class, result_onehot (single bit at result_class) and result_score SHALL hold their value until the next EMIT.
REQ-022 EMIT with image_idx<BATCH-1: increment image_idx -> REQ.
REQ-023 EMIT with image_idx=BATCH-1: done=1 for the same cycle as result_valid -> IDLE; image_idx holds BATCH-1.
REQ-024 start while busy SHALL be ignored; start held high in IDLE after done SHALL begin a new batch on the next cycle.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge with no result_valid or done; abort has priority over scores_valid and over the EMIT exit.
REQ-026 fetch_req, result_valid and done SHALL never be high outside REQ/EMIT.

Reset
REQ-027 reset SHALL force IDLE, image_idx=0, busy=0, fetch_req=0, result_valid=0, done=0, result_class=0, result_onehot=0, result_score=0, immediately and independent of clk.
REQ-028 Reset mid-batch SHALL discard all partial results; first activity after release requires a new start.

Structure
REQ-029 State enum and the clog2 width helper SHALL live in the shared package.
REQ-030 The sequential compare/track logic SHALL be one sub-module, argmax_seq (inputs: load, value, index; outputs: max value, max index).

Verification
REQ-031 BATCH=2, NUM_CLASSES=10, bias=0; image0 scores with max 500 at class 7 -> result_class=7, result_onehot=0x080, result_score=500; then image1 max at 3 -> class 3 with done=1.
REQ-032 scores all -100 except classes 2 and 5 = 40 -> result_class=2 (tie to lowest index).
REQ-033 score[4]=0x7FFFFFFF, bias[4]=1 -> result_score=+2^31 (33-bit), result_class=4.
REQ-034 scores_valid at cycle t -> result_valid exactly at t+11; scores_valid pulsed in IDLE -> no response.
REQ-035 abort asserted during SCAN of image 1 -> IDLE next cycle, no result_valid, no done, busy=0.
REQ-036 reset asserted mid-WAIT, asynchronous to clk -> all outputs zero immediately; start afterwards -> fetch_req with image_idx=0.

Source files
------------

// File: rtl/classifier_head_batch_pkg.sv
// Shared types for the batched classifier head: controller state encoding and
// the width helper used for index ports.
package classifier_head_batch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SCAN,
        ST_EMIT
    } state_t;

    // Width of an index able to count 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/classifier_head_batch_argmax_seq.sv
// Running signed max tracker, one candidate per enabled cycle. Outputs show the
// max including the current candidate, so the last step can be captured directly.
module argmax_seq #(
    parameter int VAL_W = 33,
    parameter int IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic signed [VAL_W-1:0] i_value,
    input  logic [IDX_W-1:0]        i_index,
    output logic signed [VAL_W-1:0] o_max,
    output logic [IDX_W-1:0]        o_idx
);

    logic signed [VAL_W-1:0] r_max;
    logic [IDX_W-1:0]        r_idx;
    logic                    w_take;

    // Strictly greater keeps the earlier index on ties.
    assign w_take = i_load || (i_value > r_max);
    assign o_max  = w_take ? i_value : r_max;
    assign o_idx  = w_take ? i_index : r_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_en) begin
            r_max <= o_max;
            r_idx <= o_idx;
        end
    end

endmodule

// File: rtl/classifier_head_batch.sv
// Batch controller: fetches each image's class scores, adds bias, scans for the
// argmax one class per cycle and emits the winning class/score per image.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | one-cycle fetch request for image_idx
//   WAIT  | waiting for scores_valid, biased sums registered on arrival
//   SCAN  | one class per cycle through the argmax tracker
//   EMIT  | result_valid (and done on the last image)
module classifier_head_batch
    import classifier_head_batch_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH,
    parameter int NUM_CLASSES = 10,
    parameter int BATCH       = 10,
    localparam int IDX_W      = clog2_min1(BATCH),
    localparam int CLS_W      = clog2_min1(NUM_CLASSES),
    localparam int SUM_W      = ACC_WIDTH + 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   fetch_req,
    output logic [IDX_W-1:0]                       image_idx,
    input  logic                                   scores_valid,
    input  logic [NUM_CLASSES-1:0][ACC_WIDTH-1:0]  scores,
    input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] bias,
    output logic                                   busy,
    output logic                                   result_valid,
    output logic [CLS_W-1:0]                       result_class,
    output logic [NUM_CLASSES-1:0]                 result_onehot,
    output logic signed [SUM_W-1:0]                result_score,
    output logic                                   done
);

    state_t                  r_state, w_next;
    logic [IDX_W-1:0]        r_img;
    logic [CLS_W-1:0]        r_k;
    logic signed [SUM_W-1:0] r_sum [NUM_CLASSES];
    logic [CLS_W-1:0]        r_class;
    logic [NUM_CLASSES-1:0]  r_onehot;
    logic signed [SUM_W-1:0] r_score;
    logic                    w_last_cls, w_last_img, w_accept, w_capture, w_scan;
    logic signed [SUM_W-1:0] w_max;
    logic [CLS_W-1:0]        w_max_idx;

    assign w_scan     = (r_state == ST_SCAN);
    assign w_last_cls = (r_k == CLS_W'(NUM_CLASSES-1));
    assign w_last_img = (r_img == IDX_W'(BATCH-1));
    assign w_accept   = (r_state == ST_WAIT) && scores_valid && !abort;
    assign w_capture  = w_scan && w_last_cls && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state != ST_IDLE && abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_next = ST_REQ;
                ST_REQ:  w_next = ST_WAIT;
                ST_WAIT: if (scores_valid) w_next = ST_SCAN;
                ST_SCAN: if (w_last_cls) w_next = ST_EMIT;
                ST_EMIT: w_next = w_last_img ? ST_IDLE : ST_REQ;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (r_state != ST_IDLE);
        fetch_req    = (r_state == ST_REQ);
        result_valid = (r_state == ST_EMIT) && !abort;
        done         = result_valid && w_last_img;
    end

    // Sums are one bit wider than the scores so score+bias can never wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CLASSES; k++) r_sum[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < NUM_CLASSES; k++)
                r_sum[k] <= SUM_W'($signed(scores[k])) + SUM_W'($signed(bias[k]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_img    <= '0;
            r_k      <= '0;
            r_class  <= '0;
            r_onehot <= '0;
            r_score  <= '0;
        end else begin
            if (r_state == ST_IDLE && start)
                r_img <= '0;
            else if (r_state == ST_EMIT && !abort && !w_last_img)
                r_img <= r_img + 1'b1;

            if (w_accept)
                r_k <= '0;
            else if (w_scan)
                r_k <= r_k + 1'b1;

            if (w_capture) begin
                r_class  <= w_max_idx;
                r_onehot <= NUM_CLASSES'(1) << w_max_idx;
                r_score  <= w_max;
            end
        end
    end

    argmax_seq #(
        .VAL_W (SUM_W),
        .IDX_W (CLS_W)
    ) u_argmax (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_scan),
        .i_load  (r_k == '0),
        .i_value (r_sum[r_k]),
        .i_index (r_k),
        .o_max   (w_max),
        .o_idx   (w_max_idx)
    );

    assign image_idx     = r_img;
    assign result_class  = r_class;
    assign result_onehot = r_onehot;
    assign result_score  = r_score;

endmodule

// File: tb/tb_classifier_head_batch.sv
// Scoreboard bench: the driver plays the score fetcher and queues the expected
// argmax per image; a monitor pops and compares whenever result_valid appears.
module tb_classifier_head_batch;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NC = 10;
    localparam int NB = 2;

    logic                   clk = 1'b0;
    logic                   reset, start, abort, scores_valid;
    logic [NC-1:0][AW-1:0]  scores;
    logic [NC-1:0][DW-1:0]  bias;
    logic                   fetch_req, busy, result_valid, done;
    logic [0:0]             image_idx;
    logic [3:0]             result_class;
    logic [NC-1:0]          result_onehot;
    logic signed [AW:0]     result_score;

    typedef struct {
        int     cls;
        longint score;
        bit     last;
        int     due;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     done_cyc = -100;
    int     last_cls = 0;
    longint last_score = 0;

    classifier_head_batch #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .NUM_CLASSES (NC),
        .BATCH       (NB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .fetch_req     (fetch_req),
        .image_idx     (image_idx),
        .scores_valid  (scores_valid),
        .scores        (scores),
        .bias          (bias),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_class  (result_class),
        .result_onehot (result_onehot),
        .result_score  (result_score),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Reference: biased score per class in wide arithmetic, first strict maximum wins.
    function automatic exp_t model(input bit last, input int due);
        exp_t   e;
        longint s;
        e.cls = 0; e.score = 0; e.last = last; e.due = due;
        for (int k = 0; k < NC; k++) begin
            s = longint'($signed(scores[k])) + longint'($signed(bias[k]));
            if (k == 0 || s > e.score) begin
                e.score = s;
                e.cls   = k;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (result_valid || done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: result_valid=%0b done=%0b, required 0 with nothing pending",
                             result_valid, done);
                end else begin
                    mon_e = q.pop_front();
                    check("result_valid", result_valid, 1);
                    check("result_latency", cyc, mon_e.due);
                    check("result_class", result_class, mon_e.cls);
                    check("result_onehot", result_onehot, longint'(1) << mon_e.cls);
                    check("result_score", result_score, mon_e.score);
                    check("done", done, mon_e.last);
                    last_cls   = mon_e.cls;
                    last_score = mon_e.score;
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                check("result_latency", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    task automatic gen_bias(input int pat);
        for (int k = 0; k < NC; k++) begin
            case (pat)
                0:       bias[k] = DW'($urandom);
                4:       bias[k] = DW'($urandom_range(0, 2)) - DW'(1);
                default: bias[k] = '0;
            endcase
        end
        if (pat == 3) bias[4] = DW'(1);
    endtask

    task automatic gen_scores(input int pat, input int img);
        for (int k = 0; k < NC; k++) begin
            case (pat)
                0:       scores[k] = AW'($urandom);
                2:       scores[k] = AW'(-100);
                4:       scores[k] = AW'($urandom_range(0, 3));
                default: scores[k] = AW'($urandom_range(0, 1400)) - AW'(1000);
            endcase
        end
        if (pat == 1) scores[(img == 0) ? 7 : 3] = AW'(500);
        if (pat == 2) begin
            scores[2] = AW'(40);
            scores[5] = AW'(40);
        end
        if (pat == 3) scores[4] = 32'h7FFF_FFFF;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("fetch_seen", ok, 1);
    endtask

    // chained: start was left high by the previous batch; abort_img >= 0 cancels that image mid-scan.
    task automatic run_batch(input int pat, input bit keep_start, input bit chained, input int abort_img);
        bit   ok;
        exp_t e;
        gen_bias(pat);
        if (!chained) begin
            @(posedge clk); #1;
            start = 1'b1;
        end
        for (int img = 0; img < NB; img++) begin
            wait_fetch(ok);
            if (!ok) begin
                start = keep_start;
                return;
            end
            if (img == 0 && chained) check("restart_gap", cyc - done_cyc, 2);
            check("image_idx", image_idx, img);
            check("busy", busy, 1);
            if (!keep_start) start = 1'b0;
            @(posedge clk); #1;
            check("fetch_req_one_cycle", fetch_req, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            gen_scores(pat, img);
            e = model(img == NB-1, cyc + NC + 1);
            if (img != abort_img) q.push_back(e);
            scores_valid = 1'b1;
            @(posedge clk); #1;
            scores_valid = 1'b0;
            if (img == abort_img) begin
                repeat (4) begin
                    @(posedge clk); #1;
                end
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_fetch_req", fetch_req, 0);
                check("abort_result_valid", result_valid, 0);
                check("abort_done", done, 0);
                repeat (15) @(posedge clk);
                #1;
                check("abort_stays_idle", busy, 0);
                check("abort_class_hold", result_class, last_cls);
                check("abort_score_hold", result_score, last_score);
                return;
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", ok, 1);
        if (ok) check("image_idx_hold", image_idx, NB-1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fetch_req"}, fetch_req, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_image_idx"}, image_idx, 0);
        check({tag, "_result_class"}, result_class, 0);
        check({tag, "_result_onehot"}, result_onehot, 0);
        check({tag, "_result_score"}, result_score, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b1; start = 1'b0; abort = 1'b0; scores_valid = 1'b0;
        scores = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        #2 reset = 1'b0;

        // Scores pulsed while idle must produce nothing.
        @(posedge clk); #1;
        gen_scores(0, 0);
        scores_valid = 1'b1;
        @(posedge clk); #1;
        scores_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("idle_sv_busy", busy, 0);

        run_batch(1, 1'b0, 1'b0, -1);
        run_batch(2, 1'b0, 1'b0, -1);
        run_batch(3, 1'b0, 1'b0, -1);
        run_batch(0, 1'b1, 1'b0, -1);
        run_batch(4, 1'b1, 1'b1, -1);
        run_batch(0, 1'b0, 1'b1, -1);
        for (int i = 0; i < 6; i++) run_batch((i % 2 == 0) ? 0 : 4, 1'b0, 1'b0, -1);

        run_batch(0, 1'b0, 1'b0, 1);

        // Reset asserted between clock edges while waiting for scores.
        @(posedge clk); #1;
        start = 1'b1;
        wait_fetch(ok);
        start = 1'b0;
        @(posedge clk); #3;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_outs("async_reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_idle", busy, 0);
        run_batch(0, 1'b0, 1'b0, -1);

        repeat (5) @(posedge clk);
        check("pending_results", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
